seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Sequential restoring divider: q = a / b, r = a % b, one quotient bit per clock.
//   Inverse of the shift-add multiplier datapath.
//   Same compare/subtract stage as the multiplying adder, run in reverse.
//   Sits beside the multiplier demo and uses the same start/done handshake toward the top level.
// PARAMETERS
//   N   4   operand, quotient and remainder width in bits (N >= 2)
// PORTS
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous, active-low reset
//   start        in   1  request; sampled only in IDLE or DONE
//   dividend     in   N  a; captured on the accepted start edge
//   divisor      in   N  b; captured on the accepted start edge
//   busy         out  1  high while iterating
//   done         out  1  one-cycle pulse; quotient/remainder valid
//   quotient     out  N  registered result, held until the next accepted start
//   remainder    out  N  registered result, held until the next accepted start
//   div_by_zero  out  1  registered flag, same timing and hold rules as quotient
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, quotient, remainder and div_by_zero all 0.
//     Reset is asynchronous and may assert at any cycle.
//     Mid-operation reset aborts the division; no done pulse is produced.
//   States: IDLE -> RUN -> DONE -> IDLE.
//     DONE -> RUN directly if start=1 in DONE (back-to-back operation).
//   Accepted start (edge k, b!=0):
//     - load rem = 0 (N+1 bits), qreg = a, dreg = b, cnt = N-1;
//     - state=RUN; busy=1 from cycle k+1.
//   RUN, each edge:
//     - sh = {rem[N-1:0], qreg[N-1]}; diff = sh - {1'b0, dreg};
//     - if diff[N]==0: rem = diff, qreg = {qreg[N-2:0], 1};
//     - else: rem = sh, qreg = {qreg[N-2:0], 0};
//     - cnt decrements; the edge where cnt==0 performs the last iteration and moves to DONE.
//   Latency: busy high in cycles k+1..k+N; done=1, busy=0 in cycle k+N+1.
//     quotient = qreg, remainder = rem[N-1:0], registered on the same edge as done.
//   Divide-by-zero (b==0 at start):
//     - skip RUN; go to DONE at edge k+1;
//     - quotient = {N{1'b1}}, remainder = a, div_by_zero = 1;
//     - done pulses in cycle k+1.
//   div_by_zero clears on the next accepted start.
//   start while busy: ignored; operands do not change the computation in flight.
//   start in DONE: accepted; done drops the next cycle and busy rises.
//   Outputs hold their last result through IDLE. No output changes except on an accepted start or reset.
//   Results are exact for all 2^N x (2^N - 1) unsigned operand pairs.
//     Invariant: a == q*b + r and r < b.
// CONFIGURATION
//   SEQ_DIVIDER_SIGNED_EN undefined:
//     operands and results are unsigned (default).
//   SEQ_DIVIDER_SIGNED_EN defined:
//     - operands are two's complement;
//     - magnitudes are loaded at start; same N iterations, latency unchanged;
//     - quotient is negated if sign(a)^sign(b), truncating toward zero;
//     - remainder takes the sign of a;
//     - negation is applied on the edge that registers the results;
//     - divide-by-zero still gives quotient all-ones, remainder = a;
//     - the most-negative a with b=-1 wraps: quotient = most-negative value, remainder 0.
// TESTING (N=4 unless noted)
//   1. a=13, b=4, start 1 cycle -> busy 4 cycles; done in cycle 5; q=3, r=1, dbz=0.
//   2. a=3, b=9 -> q=0, r=3; then a=15, b=1 issued in the done cycle -> q=15, r=0 five cycles later.
//   3. a=7, b=0 -> done one cycle after start; q=4'hF, r=7, dbz=1.
//      Next op a=6, b=3 -> q=2, r=0, dbz=0.
//   4. a=9, b=2 started, then start with a=1, b=1 pulsed in cycle 2 -> ignored; q=4, r=1 at cycle 5.
//   5. rst_n low in cycle 2 of a=12, b=5 -> all outputs 0, no done.
//      After release, a=12, b=5 -> q=2, r=2.
//   6. SEQ_DIVIDER_SIGNED_EN: a=-7 (4'h9), b=2 -> q=-3 (4'hD), r=-1 (4'hF).
//      a=-8, b=-1 -> q=4'h8, r=0.
//   Plus exhaustive random sweep checking a == q*b + r against a reference model.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
// q = dividend / divisor, r = dividend % divisor, using a start/done handshake.
// A divisor of zero skips iteration: quotient all-ones, remainder = dividend.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN selects two's complement operands.
// Left undefined, operands and results are unsigned.
module seq_divider #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   // The partial remainder is always below the divisor, so N bits hold it.
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  qreg_q, qreg_d;
   logic [N-1:0]  dreg_q, dreg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  quot_q, quot_d;
   logic [N-1:0]  rmd_q, rmd_d;
   logic          dbz_q, dbz_d;

   logic [N:0]    sh;
   logic [N:0]    diff;
   logic [N-1:0]  rem_step;
   logic [N-1:0]  qreg_step;
   logic [N-1:0]  a_mag;
   logic [N-1:0]  b_mag;
   logic [N-1:0]  q_fin;
   logic [N-1:0]  r_fin;

   // Shift in the next dividend bit, then trial-subtract the divisor.
   assign sh        = {rem_q, qreg_q[N-1]};
   assign diff      = sh - {1'b0, dreg_q};
   assign rem_step  = diff[N] ? sh[N-1:0] : diff[N-1:0];
   assign qreg_step = {qreg_q[N-2:0], ~diff[N]};

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic qneg_q, qneg_d;
   logic rneg_q, rneg_d;

   // Iteration works on magnitudes; signs are reapplied when results register.
   assign a_mag = dividend[N-1] ? -dividend : dividend;
   assign b_mag = divisor[N-1]  ? -divisor  : divisor;
   assign q_fin = qneg_q ? -qreg_step : qreg_step;
   assign r_fin = rneg_q ? -rem_step  : rem_step;

   // Sign flags captured with the operands on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
      end
   end

   // Quotient is negative when operand signs differ; remainder follows the dividend.
   always_comb begin
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      if ((state_q != RUN) && start) begin
         qneg_d = dividend[N-1] ^ divisor[N-1];
         rneg_d = dividend[N-1];
      end
   end
`else
   assign a_mag = dividend;
   assign b_mag = divisor;
   assign q_fin = qreg_step;
   assign r_fin = rem_step;
`endif

   // State, datapath and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rem_q   <= '0;
         qreg_q  <= '0;
         dreg_q  <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         qreg_q  <= qreg_d;
         dreg_q  <= dreg_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state logic: accept start in IDLE/DONE, iterate N times in RUN.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      qreg_d  = qreg_q;
      dreg_d  = dreg_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rmd_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = RUN;
                  rem_d   = '0;
                  qreg_d  = a_mag;
                  dreg_d  = b_mag;
                  cnt_d   = CW'(N - 1);
               end
            end
         end
         RUN: begin
            rem_d  = rem_step;
            qreg_d = qreg_step;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
               quot_d  = q_fin;
               rmd_d   = r_fin;
               dbz_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign quotient    = quot_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven and scoreboarded bench for seq_divider (N=4).
module tb_seq_divider;

   localparam int N = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
   } exp_t;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dbz;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[10];
   int   passed = 0;
   int   total  = 0;
   logic [N-1:0] lastQ;
   logic [N-1:0] lastR;

   seq_divider #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one value and tally the outcome.
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
   endtask

   // Reference division built on the language's own / and % operators.
   function automatic exp_t refDiv(input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t e;
      int   ia, ib, iq, ir;
      if (b == '0) begin
         e.q = '1;
         e.r = a;
         e.dbz = 1'b1;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         ia = int'($signed(a));
         ib = int'($signed(b));
`else
         ia = int'(a);
         ib = int'(b);
`endif
         iq = ia / ib;
         ir = ia % ib;
         e.q = iq[N-1:0];
         e.r = ir[N-1:0];
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Called at a negedge: present operands with start for one cycle, push the expectation.
   task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done, check latency and busy span, then compare against the scoreboard.
   task automatic checkOutput(input string name, input int expLat, input int startCycle);
      int   cycles;
      int   busyCnt;
      exp_t e;
      cycles  = startCycle;
      busyCnt = startCycle - 1;
      while (!done && cycles < 40) begin
         if (busy) busyCnt++;
         @(negedge clk);
         cycles++;
      end
      if (!done) begin
         total++;
         $display("[TB] FAIL %s timeout: done never rose within %0d cycles", name, cycles);
         return;
      end
      check({name, " latency"}, cycles, expLat);
      check({name, " busy cycles"}, busyCnt, expLat - 1);
      check({name, " busy at done"}, {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
         total++;
         $display("[TB] FAIL %s scoreboard: got done, expected no result", name);
         return;
      end
      e = sb.pop_front();
      check({name, " quotient"}, quotient, e.q);
      check({name, " remainder"}, remainder, e.r);
      check({name, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      lastQ = quotient;
      lastR = remainder;
   endtask

   // Main sequence: reset, vector table, hand-written corner cases, exhaustive sweep.
   initial begin
      exp_t e;
      int   lat;

`ifdef SEQ_DIVIDER_SIGNED_EN
      vecs[0] = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0};
      vecs[1] = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0};
      vecs[2] = '{4'h7, 4'h0, 4'hF, 4'h7, 1'b1};
      vecs[3] = '{4'h6, 4'h3, 4'h2, 4'h0, 1'b0};
      vecs[4] = '{4'hD, 4'h4, 4'h0, 4'hD, 1'b0};
      vecs[5] = '{4'h5, 4'hE, 4'hE, 4'h1, 1'b0};
      vecs[6] = '{4'hA, 4'hD, 4'h2, 4'h0, 1'b0};
      vecs[7] = '{4'h7, 4'hF, 4'h9, 4'h0, 1'b0};
      vecs[8] = '{4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
      vecs[9] = '{4'hC, 4'h0, 4'hF, 4'hC, 1'b1};
`else
      vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0};
      vecs[1] = '{4'd3,  4'd9,  4'd0,  4'd3, 1'b0};
      vecs[2] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
      vecs[3] = '{4'd7,  4'd0,  4'hF,  4'd7, 1'b1};
      vecs[4] = '{4'd6,  4'd3,  4'd2,  4'd0, 1'b0};
      vecs[5] = '{4'd12, 4'd5,  4'd2,  4'd2, 1'b0};
      vecs[6] = '{4'd0,  4'd1,  4'd0,  4'd0, 1'b0};
      vecs[7] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
      vecs[8] = '{4'd5,  4'd7,  4'd0,  4'd5, 1'b0};
      vecs[9] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1};
`endif

      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         lat = vecs[i].dbz ? 1 : N + 1;
         applyStimulus(vecs[i].a, vecs[i].b, '{vecs[i].q, vecs[i].r, vecs[i].dbz});
         checkOutput($sformatf("vec%0d", i), lat, 1);
         @(negedge clk);
      end

      // Divide-by-zero result must hold through idle cycles.
      applyStimulus(4'd7, 4'd0, refDiv(4'd7, 4'd0));
      checkOutput("dbz", 1, 1);
      repeat (3) @(negedge clk);
      check("dbz hold flag", {31'd0, div_by_zero}, 32'd1);
      check("dbz hold quotient", quotient, 4'hF);
      check("dbz hold done low", {31'd0, done}, 32'd0);

      // Back-to-back: second start issued during the done cycle.
      applyStimulus(4'd3, 4'd9, refDiv(4'd3, 4'd9));
      checkOutput("b2b first", N + 1, 1);
      applyStimulus(4'd15, 4'd1, refDiv(4'd15, 4'd1));
      check("b2b done drops", {31'd0, done}, 32'd0);
      check("b2b busy rises", {31'd0, busy}, 32'd1);
      checkOutput("b2b second", N + 1, 1);
      @(negedge clk);

      // Start pulsed while busy must be ignored.
      applyStimulus(4'd9, 4'd2, refDiv(4'd9, 4'd2));
      dividend = 4'd1;
      divisor  = 4'd1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("ignore start", N + 1, 2);
      repeat (N + 2) @(negedge clk);
      check("ignore no extra done", {31'd0, done}, 32'd0);
      check("ignore no extra busy", {31'd0, busy}, 32'd0);

      // Reset in the middle of an operation aborts it.
      applyStimulus(4'd12, 4'd5, refDiv(4'd12, 4'd5));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset quotient", quotient, 0);
      check("midreset remainder", remainder, 0);
      check("midreset div_by_zero", {31'd0, div_by_zero}, 32'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (N + 2) begin
         @(negedge clk);
         check("midreset no done", {31'd0, done}, 32'd0);
      end
      applyStimulus(4'd12, 4'd5, refDiv(4'd12, 4'd5));
      checkOutput("after reset", N + 1, 1);
      @(negedge clk);

      // Exhaustive sweep over every operand pair.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            e = refDiv(4'(a), 4'(b));
            lat = (b == 0) ? 1 : N + 1;
            applyStimulus(4'(a), 4'(b), e);
            checkOutput($sformatf("sweep a=%0d b=%0d", a, b), lat, 1);
`ifndef SEQ_DIVIDER_SIGNED_EN
            if (b != 0) begin
               check($sformatf("invariant a=%0d b=%0d", a, b),
                     int'(lastQ) * b + int'(lastR), a);
               check($sformatf("rem<b a=%0d b=%0d", a, b),
                     {31'd0, (int'(lastR) < b)}, 32'd1);
            end
`endif
         end
      end

      check("scoreboard empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
